// File: rtl/rw_array_atom.sv
// Stateful read/modify/write atom over an array of DEPTH state words.
// Stage 1 registers the packet; stage 2 selects the operand, reads the
// addressed entry, applies READ/WRITE/ADD/MAX and commits on the next edge.
// Back-to-back packets to the same entry need no forwarding because the
// commit of packet N lands on the same edge that samples packet N+1.
module rw_array_atom #(
    parameter int                     COUNT_WIDTH = 32,
    parameter int                     DEPTH       = 16,
    parameter int                     IDX_WIDTH   = 4,
    parameter int                     SATURATE    = 0,
    parameter logic [COUNT_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i__valid,
    input  logic [IDX_WIDTH-1:0]   i__index,
    input  logic [1:0]             i__op,
    input  logic [COUNT_WIDTH-1:0] i__constant,
    input  logic [COUNT_WIDTH-1:0] i__pkt_1,
    input  logic                   i__sel,
    output logic                   o__valid,
    output logic [COUNT_WIDTH-1:0] o__read,
    output logic [COUNT_WIDTH-1:0] o__write,
    output logic                   o__oob
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MAX   = 2'b11;

    // One extra bit so DEPTH == 2**IDX_WIDTH is representable.
    localparam logic [IDX_WIDTH:0] DEPTH_W = (IDX_WIDTH+1)'(DEPTH);

    logic                   r__valid;
    logic [IDX_WIDTH-1:0]   r__index;
    logic [1:0]             r__op;
    logic [COUNT_WIDTH-1:0] r__constant;
    logic [COUNT_WIDTH-1:0] r__pkt_1;
    logic                   r__sel;

    logic [COUNT_WIDTH-1:0] state [DEPTH];

    logic                   idx_oob;
    logic [COUNT_WIDTH-1:0] operand;
    logic [COUNT_WIDTH-1:0] old_val;
    logic [COUNT_WIDTH:0]   add_sum;
    logic [COUNT_WIDTH-1:0] add_res;
    logic [COUNT_WIDTH-1:0] new_val;

    // Stage 1: capture the packet every cycle; only the valid flag matters
    // when idle, the payload registers simply follow the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r__valid    <= 1'b0;
            r__index    <= '0;
            r__op       <= '0;
            r__constant <= '0;
            r__pkt_1    <= '0;
            r__sel      <= 1'b0;
        end else begin
            r__valid    <= i__valid;
            r__index    <= i__index;
            r__op       <= i__op;
            r__constant <= i__constant;
            r__pkt_1    <= i__pkt_1;
            r__sel      <= i__sel;
        end
    end

    // Stage 2: operand select, entry read and op evaluation.
    always_comb begin
        operand = r__sel ? r__pkt_1 : r__constant;
        idx_oob = ({1'b0, r__index} >= DEPTH_W);
        old_val = '0;
        if (!idx_oob) begin
            old_val = state[r__index];
        end

        // Sum kept one bit wider so the carry-out decides saturation.
        add_sum = {1'b0, old_val} + {1'b0, operand};
        add_res = add_sum[COUNT_WIDTH-1:0];
        if ((SATURATE != 0) && add_sum[COUNT_WIDTH]) begin
            add_res = '1;
        end

        new_val = old_val;
        case (r__op)
            OP_READ:  new_val = old_val;
            OP_WRITE: new_val = operand;
            OP_ADD:   new_val = add_res;
            OP_MAX:   new_val = (operand > old_val) ? operand : old_val;
            default:  new_val = old_val;
        endcase
    end

    // Commit: write back the entry and publish the pre/post values.
    // Reset wins over an in-flight packet, which is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i] <= INIT_VALUE;
            end
            o__valid <= 1'b0;
            o__read  <= '0;
            o__write <= '0;
            o__oob   <= 1'b0;
        end else if (r__valid) begin
            o__valid <= 1'b1;
            if (idx_oob) begin
                o__read  <= '0;
                o__write <= '0;
                o__oob   <= 1'b1;
            end else begin
                state[r__index] <= new_val;
                o__read  <= old_val;
                o__write <= new_val;
                o__oob   <= 1'b0;
            end
        end else begin
            o__valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rw_array_atom.sv
// Bench for rw_array_atom: two instances share one stimulus stream.
//   dut_a: DEPTH=10, wrapping ADD, INIT_VALUE=0
//   dut_b: DEPTH=16, saturating ADD, INIT_VALUE=5
// A packet-ordered reference model predicts every output each cycle.
module tb_rw_array_atom;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [3:0]    i_index;
    logic [1:0]    i_op;
    logic [CW-1:0] i_constant;
    logic [CW-1:0] i_pkt_1;
    logic          i_sel;

    logic          a_valid, b_valid, a_oob, b_oob;
    logic [CW-1:0] a_read, a_write, b_read, b_write;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rw_array_atom #(.COUNT_WIDTH(CW), .DEPTH(10), .IDX_WIDTH(4), .SATURATE(0),
                    .INIT_VALUE(32'd0)) dut_a (
        .clk(clk), .rst(rst), .i__valid(i_valid), .i__index(i_index), .i__op(i_op),
        .i__constant(i_constant), .i__pkt_1(i_pkt_1), .i__sel(i_sel),
        .o__valid(a_valid), .o__read(a_read), .o__write(a_write), .o__oob(a_oob));

    rw_array_atom #(.COUNT_WIDTH(CW), .DEPTH(16), .IDX_WIDTH(4), .SATURATE(1),
                    .INIT_VALUE(32'd5)) dut_b (
        .clk(clk), .rst(rst), .i__valid(i_valid), .i__index(i_index), .i__op(i_op),
        .i__constant(i_constant), .i__pkt_1(i_pkt_1), .i__sel(i_sel),
        .o__valid(b_valid), .o__read(b_read), .o__write(b_write), .o__oob(b_oob));

    // Reference model
    int            m_depth [2] = '{10, 16};
    bit            m_sat   [2] = '{1'b0, 1'b1};
    logic [CW-1:0] m_init  [2] = '{32'd0, 32'd5};
    logic [CW-1:0] m_state [2][16];
    logic          e_valid [2];
    logic [CW-1:0] e_read  [2];
    logic [CW-1:0] e_write [2];
    logic          e_oob   [2];

    // Packet accepted at the previous edge, waiting to commit.
    logic          p_valid;
    logic [3:0]    p_index;
    logic [1:0]    p_op;
    logic [CW-1:0] p_operand;

    function automatic logic [CW-1:0] apply_op(logic [CW-1:0] old, logic [1:0] op,
                                               logic [CW-1:0] opd, bit sat);
        longint unsigned s;
        case (op)
            2'd0: return old;
            2'd1: return opd;
            2'd2: begin
                s = 64'(old) + 64'(opd);
                if (s > 64'hFFFF_FFFF) return sat ? 32'hFFFF_FFFF : 32'(s - 64'h1_0000_0000);
                return 32'(s);
            end
            default: return (opd > old) ? opd : old;
        endcase
    endfunction

    task automatic model_edge();
        logic [CW-1:0] old;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int e = 0; e < 16; e++) m_state[d][e] = m_init[d];
                e_valid[d] = 1'b0; e_read[d] = '0; e_write[d] = '0; e_oob[d] = 1'b0;
            end else if (p_valid) begin
                e_valid[d] = 1'b1;
                if (int'(p_index) >= m_depth[d]) begin
                    e_read[d] = '0; e_write[d] = '0; e_oob[d] = 1'b1;
                end else begin
                    old = m_state[d][p_index];
                    m_state[d][p_index] = apply_op(old, p_op, p_operand, m_sat[d]);
                    e_read[d] = old; e_write[d] = m_state[d][p_index]; e_oob[d] = 1'b0;
                end
            end else begin
                e_valid[d] = 1'b0;
            end
        end
        p_valid   = rst ? 1'b0 : i_valid;
        p_index   = i_index;
        p_op      = i_op;
        p_operand = i_sel ? i_pkt_1 : i_constant;
    endtask

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_valid", 32'(a_valid), 32'(e_valid[0]));
        chk("a_read",  a_read,       e_read[0]);
        chk("a_write", a_write,      e_write[0]);
        chk("a_oob",   32'(a_oob),   32'(e_oob[0]));
        chk("b_valid", 32'(b_valid), 32'(e_valid[1]));
        chk("b_read",  b_read,       e_read[1]);
        chk("b_write", b_write,      e_write[1]);
        chk("b_oob",   32'(b_oob),   32'(e_oob[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pkt(input logic [3:0] idx, input logic [1:0] op,
                       input logic [CW-1:0] c, input logic [CW-1:0] p, input logic sel);
        i_valid = 1'b1; i_index = idx; i_op = op; i_constant = c; i_pkt_1 = p; i_sel = sel;
        cycle();
    endtask

    task automatic idle();
        i_valid = 1'b0;
        cycle();
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_index = '0; i_op = '0;
        i_constant = '0; i_pkt_1 = '0; i_sel = 1'b0;
        p_valid = 1'b0; p_index = '0; p_op = '0; p_operand = '0;
        cycle();
        cycle();
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        rst = 1'b0;

        // READ of a fresh entry returns INIT_VALUE on both sides
        pkt(4'd3, 2'd0, 32'd0, 32'd0, 1'b0);
        idle();
        chk("t1_a_valid", 32'(a_valid), 32'd1);
        chk("t1_a_read",  a_read,  32'd0);
        chk("t1_b_read",  b_read,  32'd5);
        chk("t1_b_write", b_write, 32'd5);

        // WRITE from packet field then immediate READ
        pkt(4'd2, 2'd1, 32'h1234, 32'hAB, 1'b1);
        pkt(4'd2, 2'd0, 32'h0, 32'h0, 1'b0);
        idle();
        chk("t2_a_read",  a_read,  32'hAB);
        chk("t2_a_write", a_write, 32'hAB);

        // Four back-to-back ADD 1 to the same entry, no bubbles
        for (int k = 0; k < 4; k++) begin
            pkt(4'd7, 2'd2, 32'd1, 32'd99, 1'b0);
            if (k > 0) begin
                chk("t3_a_write", a_write, 32'(k));
                chk("t3_a_read",  a_read,  32'(k - 1));
                chk("t3_b_write", b_write, 32'(5 + k));
            end
        end
        idle();
        chk("t3_a_last", a_write, 32'd4);
        chk("t3_valid",  32'(a_valid), 32'd1);
        idle();

        // ADD near the top: wrap on dut_a, clamp on dut_b
        pkt(4'd5, 2'd1, 32'hFFFF_FFFE, 32'd0, 1'b0);
        pkt(4'd5, 2'd2, 32'd3, 32'd0, 1'b0);
        idle();
        chk("t4_a_wrap", a_write, 32'h0000_0001);
        chk("t4_b_sat",  b_write, 32'hFFFF_FFFF);

        // MAX sequence with an interleaved write to a neighbour
        pkt(4'd1, 2'd3, 32'd0, 32'd9, 1'b1);
        pkt(4'd0, 2'd1, 32'd7, 32'd0, 1'b0);
        pkt(4'd1, 2'd3, 32'd4, 32'd0, 1'b0);
        pkt(4'd1, 2'd3, 32'd0, 32'd12, 1'b1);
        chk("t5_max4", a_write, 32'd9);
        idle();
        chk("t5_max12", a_write, 32'd12);
        pkt(4'd0, 2'd0, 32'd0, 32'd0, 1'b0);
        idle();
        chk("t5_idx0", a_read, 32'd7);

        // Out-of-range index on dut_a (in range on dut_b)
        pkt(4'd12, 2'd1, 32'h55, 32'd0, 1'b0);
        idle();
        chk("t6_a_oob",   32'(a_oob), 32'd1);
        chk("t6_a_write", a_write, 32'd0);
        chk("t6_b_write", b_write, 32'h55);
        for (int e = 0; e < 16; e++) pkt(4'(e), 2'd0, 32'd0, 32'd0, 1'b0);
        idle();

        // Reset with a packet in flight: dropped, state back to INIT_VALUE
        pkt(4'd2, 2'd1, 32'h77, 32'd0, 1'b0);
        rst = 1'b1;
        i_valid = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        chk("t6_rst_drop", 32'(a_valid), 32'd0);
        pkt(4'd2, 2'd0, 32'd0, 32'd0, 1'b0);
        idle();
        chk("t6_rst_a", a_read, 32'd0);
        chk("t6_rst_b", b_read, 32'd5);

        // Randomised traffic, occasional resets
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            i_valid    = ($urandom_range(0, 3) != 0);
            i_index    = 4'($urandom_range(0, 15));
            i_op       = 2'($urandom_range(0, 3));
            i_sel      = 1'($urandom_range(0, 1));
            i_constant = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 15)
                                                     : 32'($urandom_range(0, 20));
            i_pkt_1    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
            cycle();
        end
        rst = 1'b0;
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
